// File: rtl/keypad_scan_fifo_if.sv
// Read-side bus of the keypad scanner's key buffer.
//   rd        : pop request from the consumer (ignored while dav=0)
//   key_data  : code at the head of the buffer, valid while dav=1
//   dav       : buffer holds at least one code
//   key_count : number of codes held
//   overflow  : sticky, set when a code was dropped on a full buffer
// master : the keypad scanner (drives data/status, samples rd)
// slave  : the consumer (drives rd)
interface keypad_scan_fifo_if #(
  parameter int CODE_W = 4,
  parameter int CNT_W  = 3
) ();
  logic              rd;
  logic [CODE_W-1:0] key_data;
  logic              dav;
  logic [CNT_W-1:0]  key_count;
  logic              overflow;

  modport master (input rd, output key_data, dav, key_count, overflow);
  modport slave  (output rd, input key_data, dav, key_count, overflow);
endinterface

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner with debounce, optional auto-repeat and a
// show-ahead key buffer.
//   clock     : system clock
//   reset     : asynchronous active-low reset
//   col       : column sense lines, active-low (pulled up off-chip)
//   row       : row drive, active-low one-hot
//   scan_tick : one-cycle pulse at each scan step (debug)
//   kb        : key buffer read bus (rd / key_data / dav / key_count / overflow)
// One row is evaluated per scan tick. A key is a single low column on the
// driven row; its code is row*COLS + column.
module keypad_scan_fifo #(
  parameter int CLK_HZ         = 50000000,
  parameter int SCAN_HZ        = 500,
  parameter int ROWS           = 4,
  parameter int COLS           = 3,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_SCANS   = 0,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [COLS-1:0]      col,
  output logic [ROWS-1:0]      row,
  output logic                 scan_tick,
  keypad_scan_fifo_if.master   kb
);

  localparam int DIV    = CLK_HZ / SCAN_HZ;
  localparam int TW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RW     = $clog2(ROWS);
  localparam int CW     = $clog2(COLS);
  localparam int CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int NW     = AW + 1;
  localparam int DW     = $clog2(DEBOUNCE_SCANS + 1);
  localparam int PW     = (REPEAT_SCANS > 0) ? $clog2(REPEAT_SCANS + 1) : 1;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

  // ---------------- scan tick ----------------
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick      = (tick_cnt == TW'(DIV - 1));
  assign scan_tick = tick;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // ---------------- column synchroniser ----------------
  // Idle value is all-high so a reset does not look like a key press.
  logic [COLS-1:0] col_s1, col_s2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_s1 <= '1;
      col_s2 <= '1;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;
    end
  end

  // ---------------- column decode ----------------
  logic [COLS-1:0] low;
  logic            one_low;
  logic            all_high;
  logic [CW-1:0]   sel_c;

  assign low      = ~col_s2;
  assign all_high = (low == '0);

  // Exactly one low column; two or more count as no key.
  always_comb begin
    one_low = (low != '0) && ((low & (low - COLS'(1))) == '0);
    sel_c   = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (low[i]) sel_c = CW'(i);
    end
  end

  // ---------------- scan state machine ----------------
  state_t        state;
  logic [RW-1:0] row_idx;
  logic [RW-1:0] row_adv;
  logic [CW-1:0] lat_c;
  logic [DW-1:0] cnt;
  logic [PW-1:0] rcnt;
  logic          same_key;
  logic          key_held;
  logic          deb_done;
  logic          rep_done;

  assign row_adv  = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);
  assign same_key = one_low && (sel_c == lat_c);
  assign key_held = low[lat_c];
  assign deb_done = (int'(cnt) + 1 >= DEBOUNCE_SCANS);
  assign rep_done = (int'(rcnt) + 1 >= REPEAT_SCANS);

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      assign row[gi] = (row_idx != RW'(gi));
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= SCAN;
      row_idx <= '0;
      lat_c   <= '0;
      cnt     <= '0;
      rcnt    <= '0;
    end else if (tick) begin
      case (state)
        SCAN: begin
          if (one_low) begin
            lat_c <= sel_c;
            rcnt  <= '0;
            if (DEBOUNCE_SCANS == 1) begin
              cnt   <= '0;
              state <= HOLD;
            end else begin
              cnt   <= DW'(1);
              state <= DEBOUNCE;
            end
          end else begin
            row_idx <= row_adv;
          end
        end
        DEBOUNCE: begin
          if (same_key) begin
            if (deb_done) begin
              cnt   <= '0;
              rcnt  <= '0;
              state <= HOLD;
            end else begin
              cnt <= cnt + DW'(1);
            end
          end else begin
            state   <= SCAN;
            row_idx <= row_adv;
          end
        end
        HOLD: begin
          if (all_high) begin
            rcnt <= '0;
            if (deb_done) begin
              cnt     <= '0;
              state   <= SCAN;
              row_idx <= row_adv;
            end else begin
              cnt <= cnt + DW'(1);
            end
          end else begin
            cnt <= '0;
            if (REPEAT_SCANS > 0 && key_held) begin
              rcnt <= rep_done ? '0 : rcnt + PW'(1);
            end
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  // Push strobe, decoded in the same tick cycle that the state machine
  // accepts (or repeats) a key so the buffer captures it on that edge.
  logic              push;
  logic [CW-1:0]     code_c;
  logic [CODE_W-1:0] push_code;

  always_comb begin
    push   = 1'b0;
    code_c = lat_c;
    if (tick) begin
      case (state)
        SCAN: begin
          if (one_low && DEBOUNCE_SCANS == 1) begin
            push   = 1'b1;
            code_c = sel_c;
          end
        end
        DEBOUNCE: push = same_key && deb_done;
        HOLD:     push = (REPEAT_SCANS > 0) && key_held && rep_done;
        default:  push = 1'b0;
      endcase
    end
  end

  assign push_code = CODE_W'(int'(row_idx) * COLS + int'(code_c));

  // ---------------- key buffer ----------------
  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_next;
  logic [NW-1:0]     count, count_next;
  logic [CODE_W-1:0] head_reg, head_next;
  logic              ovf_reg;
  logic              full, do_pop, do_write, drop;

  assign full        = (count == NW'(FIFO_DEPTH));
  assign do_pop      = kb.rd && (count != '0);
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign do_write    = push && (!full || do_pop);
  assign drop        = push && full && !do_pop;
  assign count_next  = count + NW'(do_write) - NW'(do_pop);
  assign rd_ptr_next = rd_ptr + AW'(do_pop);

  // The head is a register: it is loaded with the entry that will be at the
  // head after this edge. When that entry is the one being written right
  // now (buffer empty after any pop), it is forwarded from push_code.
  always_comb begin
    if (count_next == '0)                      head_next = '0;
    else if (do_write && count == NW'(do_pop)) head_next = push_code;
    else                                       head_next = mem[rd_ptr_next];
  end

  always_ff @(posedge clock) begin
    if (do_write) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_reg <= '0;
      ovf_reg  <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      head_reg <= head_next;
      if (drop)        ovf_reg <= 1'b1;
      else if (do_pop) ovf_reg <= 1'b0;
    end
  end

  assign kb.key_data  = head_reg;
  assign kb.dav       = (count != '0);
  assign kb.key_count = count;
  assign kb.overflow  = ovf_reg;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Testbench for keypad_scan_fifo: 4x3 keypad, tick every 10 clocks,
// 3-tick debounce, 4-entry buffer. dut0 has repeat disabled, dut1 repeats
// every 8 ticks. A queue models the buffer contents at the key-event level.
module tb_keypad_scan_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] col0, col1;
  logic [3:0] row0, row1;
  logic       tick0, tick1;

  always #5 clk = ~clk;

  keypad_scan_fifo_if #(.CODE_W(4), .CNT_W(3)) kb0 ();
  keypad_scan_fifo_if #(.CODE_W(4), .CNT_W(3)) kb1 ();

  keypad_scan_fifo #(
    .CLK_HZ(100), .SCAN_HZ(10), .ROWS(4), .COLS(3),
    .DEBOUNCE_SCANS(3), .REPEAT_SCANS(0), .FIFO_DEPTH(4)
  ) dut0 (
    .clock(clk), .reset(rst_n), .col(col0), .row(row0),
    .scan_tick(tick0), .kb(kb0)
  );

  keypad_scan_fifo #(
    .CLK_HZ(100), .SCAN_HZ(10), .ROWS(4), .COLS(3),
    .DEBOUNCE_SCANS(3), .REPEAT_SCANS(8), .FIFO_DEPTH(4)
  ) dut1 (
    .clock(clk), .reset(rst_n), .col(col1), .row(row1),
    .scan_tick(tick1), .kb(kb1)
  );

  // Keypad model: one pressed key (key_r, key_c) and an optional two-key
  // chord on row 0 (columns 0 and 1).
  bit key_on   = 1'b0;
  bit multi_on = 1'b0;
  int key_r    = 0;
  int key_c    = 0;

  function automatic logic [2:0] col_for(input logic [3:0] rv, input bit on,
                                         input int r, input int c, input bit multi);
    logic [2:0] v;
    v = 3'b111;
    if (on && rv[r] == 1'b0) v[c] = 1'b0;
    if (multi && rv[0] == 1'b0) v = v & 3'b100;
    return v;
  endfunction

  assign col0 = col_for(row0, key_on, key_r, key_c, multi_on);
  assign col1 = col_for(row1, key_on, key_r, key_c, multi_on);

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] q[$];
  bit         ovf_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * 10) step();
  endtask

  task automatic check_fifo(input string tag);
    check({tag, ".dav"},   32'(kb0.dav), 32'(q.size() != 0));
    check({tag, ".count"}, 32'(kb0.key_count), 32'(q.size()));
    check({tag, ".ovf"},   32'(kb0.overflow), 32'(ovf_m));
    if (q.size() != 0) check({tag, ".data"}, 32'(kb0.key_data), 32'(q[0]));
  endtask

  // A press held long enough to be found by the scan and debounced,
  // followed by a release long enough to be debounced.
  task automatic press(input int code);
    key_r  = code / 3;
    key_c  = code % 3;
    key_on = 1'b1;
    wait_ticks(9);
    key_on = 1'b0;
    wait_ticks(6);
    if (q.size() < 4) q.push_back(4'(code));
    else              ovf_m = 1'b1;
  endtask

  // Press too short for debounce acceptance (at most two tick samples).
  task automatic bounce(input int code);
    key_r  = code / 3;
    key_c  = code % 3;
    key_on = 1'b1;
    repeat (15) step();
    key_on = 1'b0;
    wait_ticks(5);
  endtask

  task automatic pop(input string tag);
    check_fifo(tag);
    kb0.rd = 1'b1;
    step();
    kb0.rd = 1'b0;
    if (q.size() != 0) begin
      q.delete(0);
      ovf_m = 1'b0;
    end
  endtask

  // Returns just after the tick on which the scan moved onto row r.
  task automatic align_row(input int r);
    logic [3:0] want;
    bit pt;
    bit found;
    want  = ~(4'b0001 << r);
    pt    = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      step();
      if (pt && row0 == want) found = 1'b1;
      pt = tick0;
    end
    check("align_row", 32'(found), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, rises, trans, t, pushes;
    bit  pdav, ptick, found;
    logic [3:0] prow;

    kb0.rd = 1'b0;
    kb1.rd = 1'b0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;

    // ---- 1: reset and first tick ----
    repeat (5) step();
    check("t1.rst_row", 32'(row0), 32'hE);
    rst_n = 1'b1;
    check("t1.row",   32'(row0), 32'hE);
    check("t1.tick",  32'(tick0), 32'd0);
    check("t1.data",  32'(kb0.key_data), 32'd0);
    check_fifo("t1");
    // The tick occupies the 10th cycle after release (counter reaches 9).
    n = 0;
    found = 1'b0;
    while (!found && n < 50) begin
      step();
      n++;
      found = tick0;
    end
    check("t1.first_tick", 32'(n), 32'd9);
    step();
    check("t1.row_adv", 32'(row0), 32'hD);
    check("t1.tick_off", 32'(tick0), 32'd0);

    // ---- 2: clean press of code 7, held 10 ticks ----
    key_r = 2; key_c = 1; key_on = 1'b1;
    rises = 0; pdav = kb0.dav; ptick = tick0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (kb0.dav && !pdav) begin
        rises++;
        check("t2.dav_after_tick", 32'(ptick), 32'd1);
      end
      pdav  = kb0.dav;
      ptick = tick0;
    end
    check("t2.pushes", 32'(rises), 32'd1);
    q.push_back(4'd7);
    check_fifo("t2.held");
    key_on = 1'b0;
    wait_ticks(6);
    pop("t2.pop");
    check_fifo("t2.after");

    // ---- 3: bounce on row 0, then a two-column chord ----
    align_row(0);
    key_r = 0; key_c = 0; key_on = 1'b1;
    repeat (20) step();
    key_on = 1'b0;
    wait_ticks(3);
    check_fifo("t3.bounce");
    multi_on = 1'b1;
    trans = 0;
    prow  = row0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (row0 != prow) trans++;
      prow = row0;
    end
    multi_on = 1'b0;
    check("t3.row_steps", 32'(trans), 32'd8);
    check_fifo("t3.multi");

    // ---- 4: overflow ----
    press(0); press(4); press(8); press(11); press(2);
    check_fifo("t4.full");
    for (int i = 0; i < 4; i++) pop($sformatf("t4.pop%0d", i));
    check_fifo("t4.empty");

    // ---- random key / read / bounce mix ----
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    press(int'($urandom_range(0, 11)));
        2:       pop($sformatf("rnd%0d.pop", i));
        default: bounce(int'($urandom_range(0, 11)));
      endcase
      check_fifo($sformatf("rnd%0d", i));
    end
    while (q.size() != 0) pop("rnd.drain");
    if (ovf_m) pop("rnd.clr");
    check_fifo("rnd.done");

    // ---- 6: push and pop in the same cycle while full ----
    press(1); press(3); press(6); press(9);
    check_fifo("t6.full");
    align_row(3);
    key_r = 3; key_c = 1; key_on = 1'b1;
    t = 0;
    for (int i = 0; i < 40 && t < 3; i++) begin
      step();
      if (tick0) t++;
    end
    check("t6.tick3", 32'(t), 32'd3);
    check_fifo("t6.pre");
    kb0.rd = 1'b1;
    step();
    kb0.rd = 1'b0;
    q.delete(0);
    q.push_back(4'd10);
    check_fifo("t6.same_cycle");
    key_on = 1'b0;
    wait_ticks(6);
    for (int i = 0; i < 4; i++) pop($sformatf("t6.pop%0d", i));
    check_fifo("t6.empty");

    // reset while debouncing
    press(4);
    check_fifo("t6.one");
    align_row(0);
    key_r = 0; key_c = 0; key_on = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = tick0;
    end
    step();
    rst_n = 1'b0;
    #1;
    check("t6.rst_row",   32'(row0), 32'hE);
    check("t6.rst_dav",   32'(kb0.dav), 32'd0);
    check("t6.rst_count", 32'(kb0.key_count), 32'd0);
    check("t6.rst_ovf",   32'(kb0.overflow), 32'd0);
    q.delete();
    ovf_m  = 1'b0;
    key_on = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("t6.post_row", 32'(row0), 32'hE);
    check_fifo("t6.post");

    // ---- 5: auto-repeat on dut1, code 5 ----
    align_row(1);
    key_r = 1; key_c = 2; key_on = 1'b1;
    pushes = 0;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (kb1.rd) kb1.rd = 1'b0;
      else if (kb1.dav) begin
        check($sformatf("t5.push%0d.at", pushes), 32'(i), 32'(30 + 80 * pushes));
        check($sformatf("t5.push%0d.code", pushes), 32'(kb1.key_data), 32'd5);
        pushes++;
        kb1.rd = 1'b1;
      end
      if (i == 330) key_on = 1'b0;
    end
    kb1.rd = 1'b0;
    check("t5.pushes", 32'(pushes), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
Parametrised successor to the team's 4x3 keypad input stage. It scans a ROWS x COLS matrix keypad from an internally generated scan tick, debounces presses, and optionally auto-repeats held keys. Codes are buffered in a show-ahead FIFO with a read handshake, so bursts of key presses are not lost. It sits between the board keypad pins and the register/memory datapath, replacing the fixed-rate scanner and single-entry data/dav pair.

Parameters:
CLK_HZ, 50000000, input clock frequency
SCAN_HZ, 500, scan tick rate; one row is evaluated per tick
ROWS, 4, keypad rows (>=2)
COLS, 3, keypad columns (>=2)
DEBOUNCE_SCANS, 3, consecutive stable ticks needed to accept a press or a release (>=1)
REPEAT_SCANS, 0, held-key repeat interval in ticks; 0 disables repeat
FIFO_DEPTH, 4, key buffer entries (power of 2, >=2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
col  in  COLS  column sense lines, active-low (pulled up off-chip)
row  out  ROWS  row drive, active-low one-hot
rd  in  1  pop request; pops the head entry when dav=1
key_data  out  CODE_W  FIFO head code; CODE_W=max(1,clog2(ROWS*COLS))
dav  out  1  FIFO not empty
key_count  out  clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky flag: a code was dropped because the FIFO was full
scan_tick  out  1  one-cycle tick pulse, for debug

Behaviour:
- Reset (reset=0, asynchronous): tick counter=0, row index=0, row=~1 (row0 driven), state SCAN, FIFO empty, dav=0, key_count=0, key_data=0, overflow=0, scan_tick=0.
- col passes through a 2-FF synchroniser. All decisions use the synchronised value at a tick.
- Tick: a counter runs 0..DIV-1 with DIV=CLK_HZ/SCAN_HZ. scan_tick=1 for the single cycle where counter==DIV-1.
- Code: the sampled key is a single low column c on the driven row r. code = r*COLS + c.
- State machine; state changes only on ticks:
  - SCAN: if exactly one column is low, latch (r,c), set cnt=1 and go to DEBOUNCE; the row stays driven. Otherwise advance r, wrapping ROWS-1 to 0. Zero or multiple low columns count as no key.
  - DEBOUNCE: if the same single column is low, cnt++. When cnt reaches DEBOUNCE_SCANS, push the code, set cnt=0 and rcnt=0, and go to HOLD. Otherwise (released or different column), return to SCAN and advance r. With DEBOUNCE_SCANS=1, the push happens on the tick that enters DEBOUNCE is skipped: go straight from SCAN, push, then HOLD.
  - HOLD: row held. If all columns are high, cnt++ and rcnt=0. Otherwise cnt=0. When cnt reaches DEBOUNCE_SCANS, go to SCAN and advance r.
  - HOLD repeat: if REPEAT_SCANS>0 and the key is still low, rcnt++. When rcnt reaches REPEAT_SCANS, push the code again and set rcnt=0.
- FIFO timing and ordering:
  - A push is registered; dav and key_data update on the clock cycle after the push tick.
  - key_data is valid whenever dav=1.
  - rd with dav=1 pops; the next head appears the following cycle. rd with dav=0 is ignored.
- FIFO boundary cases:
  - Push while full with no pop: the code is dropped and overflow=1.
  - Push and pop in the same cycle: both take effect and key_count is unchanged. This holds even when full, so no drop occurs.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow clears on any accepted pop, unless a drop occurs in that same cycle, in which case overflow=1.
- Reset mid-operation: the FIFO contents are discarded and everything returns to reset values.

Test Plan:
Common parameters unless stated: CLK_HZ=100, SCAN_HZ=10 (tick every 10 clocks), ROWS=4, COLS=3, DEBOUNCE_SCANS=3, FIFO_DEPTH=4, REPEAT_SCANS=0.

1. Reset: hold reset=0 for 5 cycles, then release -> row=4'b1110, dav=0, key_count=0, overflow=0. The first scan_tick arrives 10 cycles after release, and row then moves to 4'b1101.
2. Clean press: drive col[1]=0 only while row[2]=0, holding 10 ticks -> exactly one push, key_data=7, dav=1, key_count=1. No further pushes occur while held. One rd cycle -> dav=0 next cycle.
3. Bounce and multi-key: hold the key for 2 ticks, then release -> no push. Hold col=3'b100 on row0 (two low columns) -> no push, and row keeps advancing.
4. Overflow: press and release 5 distinct keys (codes 0,4,8,11,2) with no rd -> key_count=4, overflow=1. Four rds return 0,4,8,11. overflow clears on the first rd. Code 2 is never returned.
5. Repeat: with REPEAT_SCANS=8, hold code 5 for 30 ticks after acceptance -> 1+3 pushes of 5, spaced 80 clocks apart, with the FIFO read as needed.
6. Full plus simultaneous: with the FIFO full, issue rd in the same cycle as a push -> key_count stays 4, overflow=0, and the new code becomes the tail. Then pulse reset=0 mid-DEBOUNCE -> dav=0, key_count=0, row=4'b1110.
